// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage:
// fetch FSM states, the NOP bubble and instruction field slices.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush overrides load and writes a bubble
// tagged with the incoming PC.
module if_id_reg
    import if_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    input  logic            valid_in,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic            valid
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            pc    <= pc_in;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= valid_in;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, request/ready fetch FSM, one-entry
// fetch buffer for stalled responses, and branch redirect handling.
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pc_load,
    input  logic            if_id_load,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state;
    fetch_state_e    state_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] redirect_pc_n;
    logic [XLEN-1:0] target;
    logic [31:0]     buf_instr;
    logic [31:0]     buf_instr_n;
    logic            adv;
    logic            resp;
    logic            id_load;
    logic            id_flush;
    logic [31:0]     id_instr;
    logic            id_valid;
    logic            target_lsb_unused;

    assign adv    = pc_load && if_id_load;
    assign resp   = imem_req && imem_ready;
    assign target = {branch_target[XLEN-1:2], 2'b00};
    assign pc_inc = pc + XLEN'(4);

    assign target_lsb_unused = ^branch_target[1:0];

    // In DROP the PC still names the outstanding request; the
    // redirect target waits in redirect_pc until it completes.
    assign imem_req  = (state != S_HOLD);
    assign imem_addr = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_REQ;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_REQ: begin
                if (branch_taken) begin
                    state_n = resp ? S_REQ : S_DROP;
                end else if (resp && !adv) begin
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_taken || adv) begin
                    state_n = S_REQ;
                end
            end
            S_DROP: begin
                if (!branch_taken && resp) begin
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    always_comb begin
        pc_n          = pc;
        redirect_pc_n = redirect_pc;
        buf_instr_n   = buf_instr;
        id_load       = 1'b0;
        id_flush      = branch_taken;
        id_instr      = NOP_INSTR;
        id_valid      = 1'b0;
        unique case (state)
            S_REQ: begin
                if (branch_taken) begin
                    if (resp) begin
                        pc_n = target;
                    end else begin
                        redirect_pc_n = target;
                    end
                end else if (resp && adv) begin
                    id_load  = 1'b1;
                    id_instr = imem_rdata;
                    id_valid = 1'b1;
                    pc_n     = pc_inc;
                end else if (resp) begin
                    buf_instr_n = imem_rdata;
                    id_load     = if_id_load;
                end else begin
                    id_load = if_id_load;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    buf_instr_n = NOP_INSTR;
                    pc_n        = target;
                end else if (adv) begin
                    id_load  = 1'b1;
                    id_instr = buf_instr;
                    id_valid = 1'b1;
                    pc_n     = pc_inc;
                end
            end
            S_DROP: begin
                if (branch_taken) begin
                    redirect_pc_n = target;
                end else begin
                    if (resp) begin
                        pc_n = redirect_pc;
                    end
                    id_load = if_id_load;
                end
            end
            default: begin
                pc_n = pc;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= PC_INIT;
            redirect_pc <= PC_INIT;
            buf_instr   <= NOP_INSTR;
        end else begin
            pc          <= pc_n;
            redirect_pc <= redirect_pc_n;
            buf_instr   <= buf_instr_n;
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clock    (clock),
        .reset    (reset),
        .load     (id_load),
        .flush    (id_flush),
        .pc_in    (pc),
        .instr_in (id_instr),
        .valid_in (id_valid),
        .pc       (if_id_pc),
        .instr    (if_id_instr),
        .valid    (if_id_valid)
    );

    assign opcode = opcode_of(if_id_instr);
    assign rs1    = rs1_of(if_id_instr);
    assign rs2    = rs2_of(if_id_instr);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, stall buffering, wait states,
// redirects, reset mid-request and PC wrap-around.
module tb_if_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_load;
    logic        if_id_load;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Memory image: word at address a is {a[24:0], 7'h33}; the bus
    // carries garbage whenever no response is being given.
    function automatic logic [31:0] mem(input logic [63:0] a);
        return {a[24:0], 7'h33};
    endfunction

    assign imem_rdata = (imem_req && imem_ready) ? mem(imem_addr) : 32'hDEADBEEF;

    if_stage #(
        .XLEN(64),
        .RESET_PC(64'h0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_load       (pc_load),
        .if_id_load    (if_id_load),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .opcode        (opcode),
        .rs1           (rs1),
        .rs2           (rs2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pc_load = 1'b1;
        if_id_load = 1'b1;
        branch_taken = 1'b0;
        branch_target = 64'h0;
        imem_ready = 1'b1;
        tick();
        tick();
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr got %h exp %h", imem_addr, 64'h0); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b exp 1", imem_req); end
        checks++; if (if_id_pc !== 64'h0) begin errors++; $display("FAIL rst_ifid_pc got %h exp 0", if_id_pc); end
        checks++; if (if_id_instr !== 32'h00000013) begin errors++; $display("FAIL rst_instr got %h exp 00000013", if_id_instr); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
        checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL rst_opcode got %h exp 13", opcode); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL seq_addr0 got %h exp 0", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 64'h0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_ifid0 got %h/%b exp 0/1", if_id_pc, if_id_valid); end
        checks++; if (if_id_instr !== 32'h00000033) begin errors++; $display("FAIL seq_instr0 got %h exp 00000033", if_id_instr); end
        checks++; if (imem_addr !== 64'h4) begin errors++; $display("FAIL seq_addr4 got %h exp 4", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 64'h4 || if_id_instr !== 32'h00000233) begin errors++; $display("FAIL seq_ifid4 got %h/%h exp 4/00000233", if_id_pc, if_id_instr); end
        checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL seq_addr8 got %h exp 8", imem_addr); end
    endtask

    task automatic test_stall();
        pc_load = 1'b0;
        if_id_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b exp 0", i, imem_req); end
            checks++; if (if_id_pc !== 64'h4 || if_id_valid !== 1'b1 || if_id_instr !== 32'h00000233) begin errors++; $display("FAIL stall_hold%0d got %h/%h/%b exp 4/00000233/1", i, if_id_pc, if_id_instr, if_id_valid); end
        end
        pc_load = 1'b1;
        if_id_load = 1'b1;
        tick();
        checks++; if (if_id_pc !== 64'h8 || if_id_instr !== 32'h00000433 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_release got %h/%h/%b exp 8/00000433/1", if_id_pc, if_id_instr, if_id_valid); end
        checks++; if (imem_addr !== 64'hC || imem_req !== 1'b1) begin errors++; $display("FAIL stall_next_addr got %h/%b exp c/1", imem_addr, imem_req); end
    endtask

    task automatic test_wait_states();
        tick();
        checks++; if (if_id_pc !== 64'hC || if_id_instr !== 32'h00000633) begin errors++; $display("FAIL wait_pre got %h/%h exp c/00000633", if_id_pc, if_id_instr); end
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h00000013) begin errors++; $display("FAIL wait_bubble%0d got %h/%b exp 00000013/0", i, if_id_instr, if_id_valid); end
            checks++; if (if_id_pc !== 64'h10) begin errors++; $display("FAIL wait_bubble_pc%0d got %h exp 10", i, if_id_pc); end
            checks++; if (imem_addr !== 64'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_addr%0d got %h/%b exp 10/1", i, imem_addr, imem_req); end
        end
    endtask

    task automatic test_redirect_outstanding();
        branch_taken = 1'b1;
        branch_target = 64'h100;
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rdo_flush got %b exp 0", if_id_valid); end
        checks++; if (imem_addr !== 64'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL rdo_addr_stable1 got %h/%b exp 10/1", imem_addr, imem_req); end
        branch_target = 64'h200;
        tick();
        checks++; if (imem_addr !== 64'h10) begin errors++; $display("FAIL rdo_addr_stable2 got %h exp 10", imem_addr); end
        branch_taken = 1'b0;
        imem_ready = 1'b1;
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rdo_discard got %b exp 0", if_id_valid); end
        checks++; if (imem_addr !== 64'h200) begin errors++; $display("FAIL rdo_target got %h exp 200", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 64'h200 || if_id_instr !== 32'h00010033 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rdo_fetch got %h/%h/%b exp 200/00010033/1", if_id_pc, if_id_instr, if_id_valid); end
        checks++; if (rs1 !== 5'd2 || rs2 !== 5'd0) begin errors++; $display("FAIL rdo_rs got %0d/%0d exp 2/0", rs1, rs2); end
    endtask

    task automatic test_redirect_stall();
        pc_load = 1'b0;
        if_id_load = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0 || if_id_pc !== 64'h200) begin errors++; $display("FAIL rds_hold got %b/%h exp 0/200", imem_req, if_id_pc); end
        branch_taken = 1'b1;
        branch_target = 64'h103;
        tick();
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h00000013) begin errors++; $display("FAIL rds_flush got %h/%b exp 00000013/0", if_id_instr, if_id_valid); end
        checks++; if (imem_addr !== 64'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL rds_addr got %h/%b exp 100/1", imem_addr, imem_req); end
        branch_taken = 1'b0;
        pc_load = 1'b1;
        if_id_load = 1'b1;
        tick();
        checks++; if (if_id_pc !== 64'h100 || if_id_instr !== 32'h00008033 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rds_fetch got %h/%h/%b exp 100/00008033/1", if_id_pc, if_id_instr, if_id_valid); end
        checks++; if (rs1 !== 5'd1) begin errors++; $display("FAIL rds_rs1 got %0d exp 1", rs1); end
    endtask

    task automatic test_reset_wrap();
        imem_ready = 1'b0;
        tick();
        checks++; if (imem_addr !== 64'h104 || if_id_valid !== 1'b0) begin errors++; $display("FAIL rw_pending got %h/%b exp 104/0", imem_addr, if_id_valid); end
        #2;
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        checks++; if (imem_addr !== 64'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL rw_async_addr got %h/%b exp 0/1", imem_addr, imem_req); end
        checks++; if (if_id_pc !== 64'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h00000013) begin errors++; $display("FAIL rw_async_ifid got %h/%h/%b exp 0/00000013/0", if_id_pc, if_id_instr, if_id_valid); end
        tick();
        checks++; if (if_id_valid !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL rw_in_reset got %b/%h exp 0/0", if_id_valid, imem_addr); end
        @(negedge clock);
        reset = 1'b1;
        branch_taken = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_valid !== 1'b0) begin errors++; $display("FAIL rw_branch got %h/%b exp fffffffffffffffc/0", imem_addr, if_id_valid); end
        branch_taken = 1'b0;
        tick();
        checks++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_instr !== 32'hFFFFFE33 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rw_top_fetch got %h/%h/%b exp fffffffffffffffc/fffffe33/1", if_id_pc, if_id_instr, if_id_valid); end
        checks++; if (opcode !== 7'h33 || rs1 !== 5'd31 || rs2 !== 5'd31) begin errors++; $display("FAIL rw_fields got %h/%0d/%0d exp 33/31/31", opcode, rs1, rs2); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rw_wrap got %h exp 0", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_wait_states();
        test_redirect_outstanding();
        test_redirect_stall();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
